cache_refill_ctrl: RTL and testbench



---
 rtl/cache_refill_ctrl_pkg.sv | 26 ++
 rtl/cache_refill_ctrl_plru_victim.sv | 21 ++
 rtl/cache_refill_ctrl.sv | 146 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache geometry, refill FSM encoding and address field helpers.

`define CACHE_TAG(a) a[31:9]
`define CACHE_SET(a) a[8:5]
`define CACHE_OFF(a) a[4:0]

package cache_types;

  localparam int WAYS     = 4;
  localparam int WAY_W    = 2;
  localparam int SET_W    = 4;
  localparam int TAG_W    = 23;
  localparam int OFF_W    = 5;
  localparam int LINE_W   = 256;
  // Tag array word: {dirty, tag}
  localparam int TWORD_W  = TAG_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_REFILL,
    ST_INSTALL,
    ST_DONE
  } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_plru_victim.sv
// Victim way choice: lowest invalid way first, otherwise follow the 3-bit tree PLRU.

module plru_victim
  import cache_types::*;
(
  input  logic [2:0]       lru_bits,
  input  logic             valid [WAYS],
  output logic [WAY_W-1:0] victim
);

  // Tree PLRU pick, overridden by the lowest-index invalid way (descending scan so way 0 wins)
  always_comb begin
    victim = lru_bits[0] ? {1'b1, lru_bits[2]} : {1'b0, lru_bits[1]};
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim = WAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss handler: picks a victim, writes it back if dirty, fetches the line and installs it.

module cache_refill_ctrl
  import cache_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  input  logic [2:0]         lru_bits,
  input  logic               way_valid [WAYS],
  input  logic [TWORD_W-1:0] way_tag   [WAYS],
  input  logic [LINE_W-1:0]  way_data  [WAYS],
  output logic [31:0]        dfp_addr,
  output logic               dfp_read,
  output logic               dfp_write,
  output logic [LINE_W-1:0]  dfp_wdata,
  input  logic [LINE_W-1:0]  dfp_rdata,
  input  logic               dfp_resp,
  output logic               data_web  [WAYS],
  output logic               tag_web   [WAYS],
  output logic               valid_web [WAYS],
  output logic [LINE_W-1:0]  data_wdata,
  output logic [TWORD_W-1:0] tag_wdata,
  output logic               valid_wdata,
  output logic               refill_done,
  output logic               busy
);

  refill_state_t      state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic [TWORD_W-1:0] vtag_q, vtag_d;
  logic [LINE_W-1:0]  vdata_q, vdata_d;
  logic [LINE_W-1:0]  line_q, line_d;

  logic [WAY_W-1:0]   victim_sel;
  logic               install;

  plru_victim u_plru_victim (
    .lru_bits (lru_bits),
    .valid    (way_valid),
    .victim   (victim_sel)
  );

  // State and latched miss context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      victim_q <= '0;
      vtag_q   <= '0;
      vdata_q  <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      victim_q <= victim_d;
      vtag_q   <= vtag_d;
      vdata_q  <= vdata_d;
      line_q   <= line_d;
    end
  end

  // Next-state logic; victim inputs are only sampled on the IDLE accept edge
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    victim_d = victim_q;
    vtag_d   = vtag_q;
    vdata_d  = vdata_q;
    line_d   = line_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          addr_d   = miss_addr;
          victim_d = victim_sel;
          vtag_d   = way_tag[victim_sel];
          vdata_d  = way_data[victim_sel];
          if (way_valid[victim_sel] && way_tag[victim_sel][TWORD_W-1]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_REFILL;
          end
        end
      end
      ST_WRITEBACK: begin
        if (dfp_resp) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (dfp_resp) begin
          line_d  = dfp_rdata;
          state_d = ST_INSTALL;
        end
      end
      ST_INSTALL: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from state; everything idles at zero outside its state
  always_comb begin
    dfp_addr    = '0;
    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    dfp_wdata   = '0;
    data_wdata  = '0;
    tag_wdata   = '0;
    valid_wdata = 1'b0;
    refill_done = 1'b0;
    install     = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_WRITEBACK: begin
        dfp_write = 1'b1;
        dfp_addr  = {vtag_q[TAG_W-1:0], `CACHE_SET(addr_q), OFF_W'(0)};
        dfp_wdata = vdata_q;
      end
      ST_REFILL: begin
        dfp_read = 1'b1;
        dfp_addr = {`CACHE_TAG(addr_q), `CACHE_SET(addr_q), OFF_W'(0)};
      end
      ST_INSTALL: begin
        install     = 1'b1;
        data_wdata  = line_q;
        tag_wdata   = {1'b0, `CACHE_TAG(addr_q)};
        valid_wdata = 1'b1;
      end
      ST_DONE: refill_done = 1'b1;
      default: ;
    endcase
  end

  // Active-low array write enables, asserted only for the victim way during INSTALL
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_web
      assign data_web[gi]  = !(install && (victim_q == WAY_W'(gi)));
      assign tag_web[gi]   = !(install && (victim_q == WAY_W'(gi)));
      assign valid_web[gi] = !(install && (victim_q == WAY_W'(gi)));
    end
  endgenerate

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with hand-computed expectations.

module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic [2:0]   lru_bits;
  logic         way_valid [4];
  logic [23:0]  way_tag   [4];
  logic [255:0] way_data  [4];
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic         data_web  [4];
  logic         tag_web   [4];
  logic         valid_web [4];
  logic [255:0] data_wdata;
  logic [23:0]  tag_wdata;
  logic         valid_wdata;
  logic         refill_done;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Sticky observation flags, cleared by the stimulus before each scenario
  logic overlap_seen = 1'b0;
  logic web_low_seen = 1'b0;
  logic done_seen    = 1'b0;

  logic [3:0] dweb, tweb, vweb;
  assign dweb = {data_web[3], data_web[2], data_web[1], data_web[0]};
  assign tweb = {tag_web[3], tag_web[2], tag_web[1], tag_web[0]};
  assign vweb = {valid_web[3], valid_web[2], valid_web[1], valid_web[0]};

  cache_refill_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .lru_bits    (lru_bits),
    .way_valid   (way_valid),
    .way_tag     (way_tag),
    .way_data    (way_data),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .data_web    (data_web),
    .tag_web     (tag_web),
    .valid_web   (valid_web),
    .data_wdata  (data_wdata),
    .tag_wdata   (tag_wdata),
    .valid_wdata (valid_wdata),
    .refill_done (refill_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dfp_read && dfp_write) overlap_seen <= 1'b1;
    if ((dweb != 4'hF) || (tweb != 4'hF) || (vweb != 4'hF)) web_low_seen <= 1'b1;
    if (refill_done) done_seen <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All outputs at their idle/reset values
  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 256'(busy), 256'(0));
    check_eq({tag, "_rw"}, 256'({dfp_read, dfp_write}), 256'(0));
    check_eq({tag, "_addr"}, 256'(dfp_addr), 256'(0));
    check_eq({tag, "_wdata"}, dfp_wdata, 256'(0));
    check_eq({tag, "_web"}, 256'({dweb, tweb, vweb}), 256'(12'hFFF));
    check_eq({tag, "_inst"}, 256'({data_wdata, tag_wdata, valid_wdata}), 256'(0));
    check_eq({tag, "_done"}, 256'(refill_done), 256'(0));
  endtask

  // Runs from cycle 1 (just after accept) until refill_done; pulses dfp_resp in the given cycles
  task automatic run_to_done(input int resp_a, input int resp_b, output int cyc);
    cyc = 1;
    while (!refill_done && cyc < 30) begin
      dfp_resp = (cyc == resp_a) || (cyc == resp_b);
      step();
      dfp_resp = 1'b0;
      cyc++;
    end
  endtask

  logic [255:0] line_a, line_b, line_c, vic2, garbage;
  int cyc;

  initial begin
    line_a  = {8{32'hA5A5_0001}};
    line_b  = {8{32'h1234_5678}};
    line_c  = {8{32'hCAFE_0003}};
    vic2    = {8{32'hD00D_0002}};
    garbage = {8{32'hBAD0_BAD0}};
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; lru_bits = '0;
    dfp_rdata = '0; dfp_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      way_valid[i] = 1'b0; way_tag[i] = '0; way_data[i] = '0;
    end
    step(); step();
    rst = 1'b0;
    check_idle("reset");

    // 1) set 3, all invalid -> way 0, L=1
    miss_addr = 32'h0000_0064; miss_req = 1'b1;
    step();
    check_eq("t1_read", 256'({dfp_read, dfp_write, busy}), 256'(3'b101));
    check_eq("t1_addr", 256'(dfp_addr), 256'(32'h0000_0060));
    dfp_resp = 1'b1; dfp_rdata = line_a;
    step();
    dfp_resp = 1'b0; dfp_rdata = '0;
    check_eq("t1_web", 256'({dweb, tweb, vweb}), 256'(12'hEEE));
    check_eq("t1_wdata", data_wdata, line_a);
    check_eq("t1_tag", 256'({tag_wdata, valid_wdata}), 256'({24'h000000, 1'b1}));
    check_eq("t1_nodone", 256'({refill_done, dfp_read}), 256'(0));
    step();
    miss_req = 1'b0;
    check_eq("t1_done", 256'(refill_done), 256'(1));
    step();
    check_idle("t1_after");

    // 2) all valid and clean, lru=010 -> way 1, L=3, done 5 cycles after accept
    for (int i = 0; i < 4; i++) begin
      way_valid[i] = 1'b1; way_tag[i] = 24'h000010 + 24'(i);
    end
    lru_bits = 3'b010; miss_addr = 32'h0000_1234; miss_req = 1'b1;
    dfp_rdata = line_b;
    step();
    check_eq("t2_addr", 256'({dfp_read, dfp_write, dfp_addr}), 256'({2'b10, 32'h0000_1220}));
    run_to_done(3, -1, cyc);
    miss_req = 1'b0;
    check_eq("t2_latency", 256'(cyc), 256'(5));
    step();
    check_eq("t2_idle", 256'(busy), 256'(0));

    // 2b) replay to observe the install cycle of way 1
    miss_req = 1'b1;
    step();
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    miss_req = 1'b0;
    check_eq("t2_web", 256'({dweb, tweb, vweb}), 256'(12'hDDD));
    check_eq("t2_wdata", data_wdata, line_b);
    check_eq("t2_tag", 256'(tag_wdata), 256'(24'h000009));
    step(); step();

    // 3) dirty way 2, tag 0xABC, set 5, lru=001, Lw=2 then L=1
    way_tag[2] = 24'h800ABC; way_data[2] = vic2;
    lru_bits = 3'b001; miss_addr = 32'h0002_46A4; miss_req = 1'b1;
    step();
    way_data[2] = garbage; way_tag[2] = 24'h000000;
    check_eq("t3_wr", 256'({dfp_read, dfp_write}), 256'(2'b01));
    check_eq("t3_waddr", 256'(dfp_addr), 256'(32'h0015_78A0));
    check_eq("t3_wdata", dfp_wdata, vic2);
    step();
    check_eq("t3_wr_hold", 256'({dfp_read, dfp_write}), 256'(2'b01));
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    check_eq("t3_rd", 256'({dfp_read, dfp_write, dfp_addr}), 256'({2'b10, 32'h0002_46A0}));
    dfp_resp = 1'b1; dfp_rdata = line_c;
    step();
    dfp_resp = 1'b0;
    check_eq("t3_web", 256'({dweb, tweb, vweb}), 256'(12'hBBB));
    check_eq("t3_tag", 256'(tag_wdata), 256'(24'h000123));
    check_eq("t3_wdata", data_wdata, line_c);
    step();
    miss_req = 1'b0;
    check_eq("t3_done", 256'(refill_done), 256'(1));
    step();

    // 4) reset during REFILL, then a late dfp_resp
    way_valid[0] = 1'b0;
    miss_addr = 32'h0000_0100; miss_req = 1'b1;
    step();
    check_eq("t4_read", 256'(dfp_read), 256'(1));
    web_low_seen = 1'b0; done_seen = 1'b0;
    rst = 1'b1; miss_req = 1'b0;
    step();
    rst = 1'b0;
    check_idle("t4_rst");
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    step(); step();
    check_eq("t4_flags", 256'({web_low_seen, done_seen}), 256'(0));
    check_idle("t4_after");

    // 5) back-to-back misses: second (dirty way 3, set 2) held through DONE
    overlap_seen = 1'b0;
    for (int i = 0; i < 4; i++) way_valid[i] = 1'b1;
    way_tag[3] = 24'h800005; way_data[3] = vic2;
    miss_addr = 32'h0000_0020; miss_req = 1'b1; lru_bits = 3'b100; way_valid[1] = 1'b0;
    step();
    check_eq("t5a_addr", 256'(dfp_addr), 256'(32'h0000_0020));
    run_to_done(2, -1, cyc);
    check_eq("t5a_latency", 256'(cyc), 256'(4));
    way_valid[1] = 1'b1; lru_bits = 3'b101; miss_addr = 32'h0000_4E40;
    step();
    check_eq("t5_gap", 256'(busy), 256'(0));
    step();
    check_eq("t5b_wr", 256'({busy, dfp_write, dfp_addr}), 256'({2'b11, 32'h0000_0A40}));
    run_to_done(1, 2, cyc);
    miss_req = 1'b0;
    check_eq("t5b_latency", 256'(cyc), 256'(4));
    step();
    check_eq("t5_overlap", 256'(overlap_seen), 256'(0));

    // 6) dfp_resp pulse while idle is ignored
    dfp_resp = 1'b1;
    step();
    dfp_resp = 1'b0;
    check_idle("t6_idle");
    step();
    check_idle("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
